// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - four-digit packed BCD to binary converter, one digit per clock
module bcd_to_bin #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       dec0,
  input  logic [3:0]       dec1,
  input  logic [3:0]       dec2,
  input  logic [3:0]       dec3,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] value,
  output logic             error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // Captured digits, thousands in the top nibble; later input changes are ignored.
  logic [15:0] digits;
  // 14 bits holds 9999; invalid digits may wrap but the result is forced to 0 then.
  logic [13:0] acc;
  logic [13:0] acc_next;
  logic [1:0]  idx;
  logic        bad;
  logic [3:0]  cur_digit;

  // Pick the digit for this step, most significant first.
  always_comb begin
    cur_digit = digits[3:0];
    case (idx)
      2'd0:    cur_digit = digits[15:12];
      2'd1:    cur_digit = digits[11:8];
      2'd2:    cur_digit = digits[7:4];
      default: cur_digit = digits[3:0];
    endcase
  end

  // acc*10 built from two shifts so no multiplier is inferred.
  assign acc_next = (acc << 3) + (acc << 1) + {10'd0, cur_digit};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, four accumulate steps, one result step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && ready) state_d = CONV;
      CONV:    if (idx == 2'd3) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits <= '0;
      acc    <= '0;
      idx    <= '0;
      bad    <= 1'b0;
      ready  <= 1'b1;
      valid  <= 1'b0;
      value  <= '0;
      error  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && ready) begin
            digits <= {dec3, dec2, dec1, dec0};
            acc    <= '0;
            idx    <= '0;
            bad    <= 1'b0;
            ready  <= 1'b0;
          end
        end
        CONV: begin
          acc <= acc_next;
          bad <= bad | (cur_digit > 4'd9);
          idx <= idx + 2'd1;
        end
        DONE: begin
          value <= bad ? '0 : WIDTH'(acc);
          error <= bad;
          valid <= 1'b1;
          ready <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - self-checking bench for bcd_to_bin
module tb_bcd_to_bin;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  dec0;
  logic [3:0]  dec1;
  logic [3:0]  dec2;
  logic [3:0]  dec3;
  logic        ready;
  logic        valid;
  logic [15:0] value;
  logic        error;

  int passed;
  int total;

  bcd_to_bin #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .dec0  (dec0),
    .dec1  (dec1),
    .dec2  (dec2),
    .dec3  (dec3),
    .ready (ready),
    .valid (valid),
    .value (value),
    .error (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  d3;
    logic [3:0]  d2;
    logic [3:0]  d1;
    logic [3:0]  d0;
    logic [15:0] exp_value;
    logic        exp_error;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Reference: decimal weights applied directly, any digit above 9 poisons the result.
  function automatic logic [16:0] ref_model(input logic [3:0] a, b, c, d);
    int v;
    logic e;
    e = (a > 9) || (b > 9) || (c > 9) || (d > 9);
    v = int'(a) * 1000 + int'(b) * 100 + int'(c) * 10 + int'(d);
    if (e) v = 0;
    return {e, v[15:0]};
  endfunction

  // One full conversion: returns latency (negedges after accept until valid) and results.
  task automatic run_conv(input logic [3:0] a, b, c, d,
                          output logic [15:0] v, output logic e, output int lat,
                          output logic rdy_low_ok, output logic valid_after);
    @(negedge clk);
    dec3 = a; dec2 = b; dec1 = c; dec0 = d;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    rdy_low_ok = 1'b1;
    while (!valid && lat < 20) begin
      if (ready) rdy_low_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    v = value;
    e = error;
    @(negedge clk);
    valid_after = valid;
  endtask

  initial begin
    vec_t        vecs[5];
    logic [15:0] v;
    logic        e;
    int          lat;
    logic        rok;
    logic        va;
    logic [16:0] r;
    int          nvalid;
    logic [15:0] vval;
    logic        rdy_bad;
    logic        vpat_ok;
    logic        rpat_ok;
    logic        vals_ok;

    passed = 0;
    total  = 0;
    start  = 1'b0;
    dec0 = '0; dec1 = '0; dec2 = '0; dec3 = '0;
    reset = 1'b1;
    #1;
    chk("reset_ready_async", 32'(ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_value", 32'(value), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 16'd1234, 1'b0};
    vecs[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 16'h270F, 1'b0};
    vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 16'd0,    1'b0};
    vecs[3] = '{4'd0, 4'd5, 4'hA, 4'd7, 16'd0,    1'b1};
    vecs[4] = '{4'd0, 4'd0, 4'd4, 4'd2, 16'd42,   1'b0};

    for (int i = 0; i < 5; i++) begin
      run_conv(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0, v, e, lat, rok, va);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
      chk($sformatf("vec%0d_value", i), 32'(v), 32'(vecs[i].exp_value));
      chk($sformatf("vec%0d_error", i), 32'(e), 32'(vecs[i].exp_error));
      chk($sformatf("vec%0d_ready_low", i), 32'(rok), 32'd1);
      chk($sformatf("vec%0d_valid_single", i), 32'(va), 32'd0);
    end

    // Inputs change and start is reasserted while busy: result must be unaffected.
    @(negedge clk);
    dec3 = 4'd1; dec2 = 4'd2; dec1 = 4'd3; dec0 = 4'd4;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dec3 = 4'd8; dec2 = 4'd8; dec1 = 4'd8; dec0 = 4'd8;
    start = 1'b1;
    nvalid = 0;
    vval = '0;
    rdy_bad = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (valid) begin
        nvalid++;
        vval = value;
      end
      if (n >= 3 && !ready) rdy_bad = 1'b1;
      if (n == 3) start = 1'b0;
    end
    chk("busy_value", 32'(vval), 32'd1234);
    chk("busy_valid_count", 32'(nvalid), 32'd1);
    chk("busy_no_restart", 32'(rdy_bad), 32'd0);

    // Start held high: one result every 6 clocks, ready low 5 / high 1.
    @(negedge clk);
    dec3 = 4'd0; dec2 = 4'd1; dec1 = 4'd0; dec0 = 4'd0;
    start = 1'b1;
    vpat_ok = 1'b1;
    rpat_ok = 1'b1;
    vals_ok = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (valid !== (k % 6 == 5)) vpat_ok = 1'b0;
      if (ready !== (k % 6 == 5)) rpat_ok = 1'b0;
      if (valid && value !== 16'd100) vals_ok = 1'b0;
      if (k == 23) start = 1'b0;
    end
    chk("held_valid_pattern", 32'(vpat_ok), 32'd1);
    chk("held_ready_pattern", 32'(rpat_ok), 32'd1);
    chk("held_value", 32'(vals_ok), 32'd1);
    repeat (8) @(negedge clk);
    chk("held_idle_after", 32'(ready), 32'd1);

    // Async reset mid-conversion between E2 and E3.
    @(negedge clk);
    dec3 = 4'd5; dec2 = 4'd6; dec1 = 4'd7; dec0 = 4'd8;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_value", 32'(value), 32'd0);
    chk("abort_error", 32'(error), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    nvalid = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    chk("abort_no_valid", 32'(nvalid), 32'd0);
    run_conv(4'd5, 4'd6, 4'd7, 4'd8, v, e, lat, rok, va);
    chk("after_abort_value", 32'(v), 32'd5678);
    chk("after_abort_latency", 32'(lat), 32'd5);

    // Randomized conversions against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] rd[4];
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 7) == 0) rd[j] = 4'($urandom_range(10, 15));
        else rd[j] = 4'($urandom_range(0, 9));
      end
      r = ref_model(rd[0], rd[1], rd[2], rd[3]);
      run_conv(rd[0], rd[1], rd[2], rd[3], v, e, lat, rok, va);
      chk($sformatf("rand%0d_value", i), 32'(v), 32'(r[15:0]));
      chk($sformatf("rand%0d_error", i), 32'(e), 32'(r[16]));
      chk($sformatf("rand%0d_latency", i), 32'(lat), 32'd5);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Multi-cycle converter from four packed BCD digits to an unsigned binary value. It is the inverse of the display-side binary-to-BCD stage. It sits behind the keypad/UART setpoint entry path so that operator-entered RPM limits can be compared with the binary period/RPM counters. A start/ready/valid handshake frames each conversion, and invalid digits are flagged.

## Interface
- WIDTH, 16, width of the binary result; must be ≥ 14 (covers 9999).

- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  request conversion; accepted only when ready=1
- dec0  input  4  BCD units digit
- dec1  input  4  BCD tens digit
- dec2  input  4  BCD hundreds digit
- dec3  input  4  BCD thousands digit
- ready  output  1  high when idle and able to accept start
- valid  output  1  one-cycle pulse, value/error updated this cycle
- value  output  WIDTH  binary result, zero-extended; held until next completion
- error  output  1  set with valid if any captured digit > 9; held with value

## Operation
- Reset (async assert) gives state=IDLE, ready=1, valid=0, value=0, error=0, and clears all internal registers.
- States: IDLE, CONV, DONE.
- IDLE:
  - On start && ready, latch dec3..dec0 into an internal digit register and set acc=0, idx=0, bad=0, ready<=0 → CONV.
  - Digits are sampled only on the accepting edge. Later input changes have no effect.
- CONV, one digit per cycle, most significant first (dec3, dec2, dec1, dec0):
  - acc <= acc*10 + digit[idx], where acc*10 is formed as (acc<<3)+(acc<<1). No multiplier is needed.
  - bad <= bad | (digit[idx] > 9).
  - idx increments. After the 4th digit (idx==3), → DONE.
- DONE:
  - value <= bad ? 0 : acc, error <= bad, valid <= 1, ready <= 1 → IDLE.
- Arithmetic:
  - acc is at least 14 bits internally and is zero-extended to WIDTH.
  - With valid digits, no overflow is possible (max 9999 = 0x270F).
  - With invalid digits, intermediate acc is don't-care. Only the forced 0 output is checked.
- start while ready=0 is ignored and not queued.
- valid is high for exactly one cycle per accepted start.
- value and error hold between completions.

## Timing
- Edge E0 samples start with ready=1. E1–E4 accumulate digits 3..0. E5 registers the result, and valid=1, ready=1 after E5.
- Latency from the accepting edge to valid is 5 clocks.
- ready is low from after E0 to after E5.
- start sampled at E5 is ignored, because ready is still 0 at that edge.
- The earliest next accept is E6, giving a throughput of one conversion per 6 clocks with start held high.
- Reset mid-conversion:
  - Outputs return to their reset values immediately.
  - No valid pulse is produced for the aborted conversion.
  - After deassert, the block is in IDLE with ready=1.
- Reset takes priority over any simultaneous start.

## Test plan
- Digits 1,2,3,4 (dec3..dec0), start pulse at E0 → ready=0 for E1–E4; valid=1 after E5 with value=1234 (0x04D2), error=0; valid=0 the next cycle.
- Digits 9,9,9,9 → value=9999 (0x270F), error=0. Digits 0,0,0,0 → value=0, error=0, valid still pulses once.
- Digits 0,5,0xA,7 → valid after E5 with error=1, value=0. A following conversion of 0,0,4,2 → value=42, error=0.
- Change dec0..dec3 to 8,8,8,8 and assert start during E2–E5 of a 1,2,3,4 conversion → result is 1234, exactly one valid pulse, and no second conversion starts.
- Hold start=1 continuously with digits 0,1,0,0 → valid pulses every 6 cycles with value=100; ready toggles low 5 / high 1.
- Assert reset asynchronously between E2 and E3 of a 5,6,7,8 conversion → value=0, error=0, valid=0, ready=1 immediately; no valid pulse after release. A new start then converts normally.
